key_cmd_ctrl: RTL and testbench

- Front-end controller for the 9-LED thermometer bar. Takes three raw active-low push-buttons: clear, increment and decrement.
- Per key it synchronises and debounces the input, then detects the press.
- Increment and decrement auto-repeat while held.
- The three keys are arbitrated so that at most one single-cycle command pulse (clr/inc/dec) reaches the bar per clock. Inc is suppressed while the bar is full; dec is suppressed while it is empty.

---
 rtl/key_cmd_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_key_cmd_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_ctrl.sv
// Key command controller: sync, debounce, auto-repeat and arbitration
// for the clear/increment/decrement buttons of the thermometer bar.
module key_cmd_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_clr_n,
    input  logic key_inc_n,
    input  logic key_dec_n,
    input  logic bar_full,
    input  logic bar_empty,
    output logic cmd_clr,
    output logic cmd_inc,
    output logic cmd_dec,
    output logic repeat_active
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Key index 0 = clear, 1 = increment, 2 = decrement.
    logic [2:0]       keys_raw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       deb_q;
    logic [2:0]       deb_prev_q;
    logic [CNT_W-1:0] db_cnt_q [3];
    logic [2:0]       press;

    // Repeat engines: index 0 = increment, 1 = decrement.
    rpt_state_e       st_q    [2];
    logic [CNT_W-1:0] timer_q [2];
    logic [1:0]       fire;
    logic [1:0]       rep_d;

    logic clr_held;
    logic clr_d;
    logic inc_d;
    logic dec_d;

    assign keys_raw = {key_dec_n, key_inc_n, key_clr_n};
    assign press    = deb_prev_q & ~deb_q;
    assign clr_held = ~deb_q[0];

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= keys_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after it persists long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q      <= '1;
            deb_prev_q <= '1;
            for (int k = 0; k < 3; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            deb_prev_q <= deb_q;
            for (int k = 0; k < 3; k++) begin
                if (sync2_q[k] == deb_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_LAST) begin
                    deb_q[k]    <= sync2_q[k];
                    db_cnt_q[k] <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Fire requests and next-cycle REPEAT flag of each repeat engine.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            fire[i]  = 1'b0;
            rep_d[i] = 1'b0;
            case (st_q[i])
                IDLE: begin
                    fire[i] = press[i+1];
                end
                DELAY: begin
                    fire[i]  = ~deb_q[i+1] && (timer_q[i] == RD_LAST);
                    rep_d[i] = fire[i];
                end
                REPEAT: begin
                    fire[i]  = ~deb_q[i+1] && (timer_q[i] == RP_LAST);
                    rep_d[i] = ~deb_q[i+1];
                end
                default: begin
                    fire[i]  = 1'b0;
                    rep_d[i] = 1'b0;
                end
            endcase
        end
    end

    // Auto-repeat FSMs; release always wins over a timer expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]    <= IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (st_q[i])
                    IDLE: begin
                        if (press[i+1]) begin
                            st_q[i]    <= DELAY;
                            timer_q[i] <= '0;
                        end
                    end
                    DELAY: begin
                        if (deb_q[i+1]) begin
                            st_q[i] <= IDLE;
                        end else if (timer_q[i] == RD_LAST) begin
                            st_q[i]    <= REPEAT;
                            timer_q[i] <= '0;
                        end else begin
                            timer_q[i] <= timer_q[i] + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (deb_q[i+1]) begin
                            st_q[i] <= IDLE;
                        end else if (timer_q[i] == RP_LAST) begin
                            timer_q[i] <= '0;
                        end else begin
                            timer_q[i] <= timer_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        st_q[i]    <= IDLE;
                        timer_q[i] <= '0;
                    end
                endcase
            end
        end
    end

    // Arbitration: clear dominates, inc/dec collide, bar limits gate.
    always_comb begin
        clr_d = press[0];
        inc_d = fire[0] && !clr_held && !fire[1] && !bar_full;
        dec_d = fire[1] && !clr_held && !fire[0] && !bar_empty;
    end

    // Registered command pulses and repeat indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_clr       <= 1'b0;
            cmd_inc       <= 1'b0;
            cmd_dec       <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            cmd_clr       <= clr_d;
            cmd_inc       <= inc_d;
            cmd_dec       <= dec_d;
            repeat_active <= |rep_d;
        end
    end

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Bench for key_cmd_ctrl: history-based reference model checked every
// cycle, plus literal pulse-timing expectations for directed scenarios.
module tb_key_cmd_ctrl;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic key_clr_n, key_inc_n, key_dec_n;
    logic bar_full, bar_empty;
    logic cmd_clr, cmd_inc, cmd_dec, repeat_active;

    int vectors = 0;
    int miscompares = 0;

    key_cmd_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_clr_n    (key_clr_n),
        .key_inc_n    (key_inc_n),
        .key_dec_n    (key_dec_n),
        .bar_full     (bar_full),
        .bar_empty    (bar_empty),
        .cmd_clr      (cmd_clr),
        .cmd_inc      (cmd_inc),
        .cmd_dec      (cmd_dec),
        .repeat_active(repeat_active)
    );

    always #5 clk = ~clk;

    // Model state: raw samples and debounced level per edge since reset.
    bit raw_h [3][4096];
    bit deb_h [3][4096];
    bit kr [3];
    int n = 0;
    int pk [3];
    int cyc = 0;
    int t0 = 0;
    bit e_clr, e_inc, e_dec, e_rep;
    bit bf, be, prev, flip, d1, d2, clr_held;
    bit press [3];
    bit req [3];
    bit rep [3];
    bit rep_seen;
    int inc_t[$], clr_t[$], dec_t[$], m_inc_t[$];

    function automatic bit sv(int k, int j);
        return (j >= 2) ? raw_h[k][j-2] : 1'b1;
    endfunction

    function automatic bit debv(int k, int j);
        return (j >= 0) ? deb_h[k][j] : 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        kr[0] = key_clr_n;
        kr[1] = key_inc_n;
        kr[2] = key_dec_n;
        bf = bar_full;
        be = bar_empty;
        if (!rst_n) begin
            n = 0;
            pk[1] = -1;
            pk[2] = -1;
            e_clr = 0; e_inc = 0; e_dec = 0; e_rep = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                raw_h[k][n] = kr[k];
                prev = debv(k, n - 1);
                flip = (n >= D - 1);
                for (int j = n - D + 1; j <= n; j++)
                    if (sv(k, j) == prev) flip = 0;
                deb_h[k][n] = flip ? !prev : prev;
                d1 = debv(k, n - 1);
                d2 = debv(k, n - 2);
                press[k] = !d1 && d2;
                req[k] = 0;
                rep[k] = 0;
                if (k > 0) begin
                    if (d1) pk[k] = -1;
                    else if (press[k]) pk[k] = n;
                    if (pk[k] >= 0) begin
                        req[k] = (n == pk[k]) ||
                                 (n - pk[k] >= RD &&
                                  (n - pk[k] - RD) % RP == 0);
                        rep[k] = (n - pk[k] >= RD);
                    end
                end
            end
            clr_held = !debv(0, n - 1);
            e_clr = press[0];
            e_inc = req[1] && !clr_held && !req[2] && !bf;
            e_dec = req[2] && !clr_held && !req[1] && !be;
            e_rep = rep[1] || rep[2];
            n++;
        end
        #1;
        vectors++;
        if ({cmd_clr, cmd_inc, cmd_dec, repeat_active} !==
            {e_clr, e_inc, e_dec, e_rep}) begin
            miscompares++;
            $display("FAIL cycle %0d outs(clr,inc,dec,rep) got %b exp %b",
                     cyc, {cmd_clr, cmd_inc, cmd_dec, repeat_active},
                     {e_clr, e_inc, e_dec, e_rep});
        end
        if (cmd_clr === 1'b1) clr_t.push_back(cyc - t0);
        if (cmd_inc === 1'b1) inc_t.push_back(cyc - t0);
        if (cmd_dec === 1'b1) dec_t.push_back(cyc - t0);
        if (e_inc) m_inc_t.push_back(cyc - t0);
        if (repeat_active === 1'b1) rep_seen = 1;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    task automatic chk_q(input string nm, input int got[$], input int exp[$]);
        bit bad;
        bad = (got.size() != exp.size());
        if (!bad)
            foreach (exp[i]) if (got[i] != exp[i]) bad = 1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s got %p exp %p", nm, got, exp);
        end
    endtask

    task automatic start();
        inc_t.delete();
        clr_t.delete();
        dec_t.delete();
        m_inc_t.delete();
        rep_seen = 0;
        t0 = cyc + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        key_clr_n = 1; key_inc_n = 1; key_dec_n = 1;
        bar_full = 0; bar_empty = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    int eq[$];

    initial begin
        rst_n = 0;
        key_clr_n = 1; key_inc_n = 1; key_dec_n = 1;
        bar_full = 0; bar_empty = 0;
        do_reset();
        chk("reset_outs", {cmd_clr, cmd_inc, cmd_dec, repeat_active}, 0);

        // Clean inc press, held 15 cycles.
        repeat (3) @(negedge clk);
        key_inc_n = 0; start();
        repeat (15) @(negedge clk);
        key_inc_n = 1;
        repeat (20) @(negedge clk);
        eq = {6}; chk_q("clean_inc", inc_t, eq);
        chk_q("clean_inc_model", m_inc_t, eq);
        eq.delete(); chk_q("clean_no_clr", clr_t, eq);
        chk_q("clean_no_dec", dec_t, eq);
        chk("clean_no_rep", rep_seen, 0);

        // Bounce never accepted.
        do_reset();
        key_inc_n = 0; start();
        repeat (3) @(negedge clk); key_inc_n = 1;
        @(negedge clk); key_inc_n = 0;
        repeat (3) @(negedge clk); key_inc_n = 1;
        repeat (20) @(negedge clk);
        eq.delete(); chk_q("bounce_inc", inc_t, eq);

        // Held 60 cycles: auto-repeat cadence.
        do_reset();
        key_inc_n = 0; start();
        repeat (60) @(negedge clk);
        key_inc_n = 1;
        repeat (20) @(negedge clk);
        eq = {6, 26, 34, 42, 50, 58};
        chk_q("hold_inc", inc_t, eq);
        chk_q("hold_inc_model", m_inc_t, eq);
        chk("hold_rep_seen", rep_seen, 1);
        chk("hold_rep_off", repeat_active, 0);

        // inc and dec together: both dropped.
        do_reset();
        key_inc_n = 0; key_dec_n = 0; start();
        repeat (15) @(negedge clk);
        key_inc_n = 1; key_dec_n = 1;
        repeat (20) @(negedge clk);
        eq.delete(); chk_q("incdec_inc", inc_t, eq);
        chk_q("incdec_dec", dec_t, eq);

        // clr and inc together: only clr.
        do_reset();
        key_clr_n = 0; key_inc_n = 0; start();
        repeat (15) @(negedge clk);
        key_clr_n = 1; key_inc_n = 1;
        repeat (20) @(negedge clk);
        eq = {6}; chk_q("clrinc_clr", clr_t, eq);
        eq.delete(); chk_q("clrinc_inc", inc_t, eq);

        // inc held with bar full: all dropped.
        do_reset();
        bar_full = 1; key_inc_n = 0; start();
        repeat (40) @(negedge clk);
        key_inc_n = 1;
        repeat (20) @(negedge clk);
        bar_full = 0;
        eq.delete(); chk_q("full_inc", inc_t, eq);
        chk("full_rep_seen", rep_seen, 1);

        // dec with bar not empty, then with bar empty.
        do_reset();
        bar_empty = 0; key_dec_n = 0; start();
        repeat (15) @(negedge clk);
        key_dec_n = 1;
        repeat (20) @(negedge clk);
        eq = {6}; chk_q("dec_ok", dec_t, eq);
        bar_empty = 1; key_dec_n = 0; start();
        repeat (15) @(negedge clk);
        key_dec_n = 1;
        repeat (20) @(negedge clk);
        bar_empty = 0;
        eq.delete(); chk_q("dec_empty", dec_t, eq);

        // Reset in the middle of REPEAT with the key held.
        do_reset();
        key_inc_n = 0; start();
        repeat (39) @(negedge clk);
        @(posedge clk); #3;
        chk("rep_before_rst", repeat_active, 1);
        rst_n = 0; #1;
        chk("outs_in_rst", {cmd_clr, cmd_inc, cmd_dec, repeat_active}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1; start();
        repeat (40) @(negedge clk);
        eq = {6, 26, 34}; chk_q("inc_after_rst", inc_t, eq);
        key_inc_n = 1;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
